// File: rtl/seg_scan_driver_pkg.sv
// Shared types, constants and polarity helpers for the seven-segment scan driver.
package seg_scan_driver_pkg;

  `include "seg_defs.vh"

  localparam int NUM_DIG = 6;
  localparam int DIG_W   = 4;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_SHOW  = 1'b1
  } phase_t;

  function automatic logic [7:0] seg_drive(input logic [7:0] seg_hi, input logic act_low);
    return act_low ? ~seg_hi : seg_hi;
  endfunction

  function automatic logic [5:0] sel_drive(input logic [5:0] sel_hi, input logic act_low);
    return act_low ? ~sel_hi : sel_hi;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-high seven-segment pattern (bit 0 = a ... bit 6 = g).
module seg7_decode
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_0;
    unique case (i_nib)
      4'h0: o_seg = SEG_0;
      4'h1: o_seg = SEG_1;
      4'h2: o_seg = SEG_2;
      4'h3: o_seg = SEG_3;
      4'h4: o_seg = SEG_4;
      4'h5: o_seg = SEG_5;
      4'h6: o_seg = SEG_6;
      4'h7: o_seg = SEG_7;
      4'h8: o_seg = SEG_8;
      4'h9: o_seg = SEG_9;
      4'hA: o_seg = SEG_A;
      4'hB: o_seg = SEG_B;
      4'hC: o_seg = SEG_C;
      4'hD: o_seg = SEG_D;
      4'hE: o_seg = SEG_E;
      4'hF: o_seg = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg_defs.vh
// Seven-segment decode constants (active-high, gfedcba) and default scan timing.
// Pulled into seg_scan_driver_pkg so every file sees a single copy.
`ifndef SEG_DEFS_VH
`define SEG_DEFS_VH

localparam logic [6:0] SEG_0 = 7'h3F;
localparam logic [6:0] SEG_1 = 7'h06;
localparam logic [6:0] SEG_2 = 7'h5B;
localparam logic [6:0] SEG_3 = 7'h4F;
localparam logic [6:0] SEG_4 = 7'h66;
localparam logic [6:0] SEG_5 = 7'h6D;
localparam logic [6:0] SEG_6 = 7'h7D;
localparam logic [6:0] SEG_7 = 7'h07;
localparam logic [6:0] SEG_8 = 7'h7F;
localparam logic [6:0] SEG_9 = 7'h6F;
localparam logic [6:0] SEG_A = 7'h77;
localparam logic [6:0] SEG_B = 7'h7C;
localparam logic [6:0] SEG_C = 7'h39;
localparam logic [6:0] SEG_D = 7'h5E;
localparam logic [6:0] SEG_E = 7'h79;
localparam logic [6:0] SEG_F = 7'h71;

// 50 MHz system clock: 1 kHz per digit slot, 10 us dark gap between digits.
localparam int SCAN_DIV_DEF  = 50000;
localparam int BLANK_CYC_DEF = 500;

`endif

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed seven-segment driver with per-slot blanking, frame-aligned
// input snapshots and optional leading-zero suppression of the hour-tens digit.
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV    = SCAN_DIV_DEF,
  parameter int BLANK_CYC   = BLANK_CYC_DEF,
  parameter bit SEG_ACT_LOW = 1'b1,
  parameter bit SEL_ACT_LOW = 1'b1
) (
  input  logic       clk_sys,
  input  logic       nRST,
  input  logic [3:0] disp_dat_0,
  input  logic [3:0] disp_dat_1,
  input  logic [3:0] disp_dat_2,
  input  logic [3:0] disp_dat_3,
  input  logic [3:0] disp_dat_4,
  input  logic [3:0] disp_dat_5,
  input  logic [5:0] dp_mask,
  input  logic       blank_en,
  output logic [7:0] seg,
  output logic [5:0] sel,
  output logic       frame_tick
);

  localparam int                PCNT_W     = $clog2(SCAN_DIV);
  localparam logic [PCNT_W-1:0] PCNT_LAST  = PCNT_W'(SCAN_DIV - 1);
  localparam logic [PCNT_W-1:0] BLANK_END  = PCNT_W'(BLANK_CYC);
  localparam logic [2:0]        IDX_LAST   = 3'(NUM_DIG - 1);
  localparam logic [7:0]        SEG_OFF    = SEG_ACT_LOW ? 8'hFF : 8'h00;
  localparam logic [5:0]        SEL_OFF    = SEL_ACT_LOW ? 6'h3F : 6'h00;
  localparam int                CAP_W      = NUM_DIG * DIG_W;

  logic [PCNT_W-1:0] r_pcnt;
  logic [2:0]        r_idx;
  logic [CAP_W-1:0]  r_s1;
  logic [CAP_W-1:0]  r_s2;
  logic [CAP_W-1:0]  r_shadow;
  logic [7:0]        r_seg;
  logic [5:0]        r_sel;
  logic              r_frame_tick;

  logic [CAP_W-1:0]  w_din;
  logic              w_slot_end;
  logic              w_frame_end;
  phase_t            w_phase;
  logic [5:0]        w_onehot;
  logic              w_dp;
  logic [3:0]        w_cur_nib;
  logic [6:0]        w_dec;
  logic              w_lz_blank;
  logic [7:0]        w_seg_hi;
  logic [5:0]        w_sel_hi;
  logic [3:0]        w_shadow_dig [8];

  assign w_din = {disp_dat_5, disp_dat_4, disp_dat_3, disp_dat_2, disp_dat_1, disp_dat_0};

  assign w_slot_end  = (r_pcnt == PCNT_LAST);
  assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);
  assign w_phase     = (r_pcnt < BLANK_END) ? PH_BLANK : PH_SHOW;

  // Padded to 8 entries so any 3-bit slot index selects a defined digit.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_dig
      if (gi < NUM_DIG) begin : g_real
        assign w_shadow_dig[gi] = r_shadow[gi*DIG_W +: DIG_W];
      end else begin : g_pad
        assign w_shadow_dig[gi] = 4'h0;
      end
    end
    for (genvar gi = 0; gi < NUM_DIG; gi++) begin : g_sel
      assign w_onehot[gi] = (r_idx == 3'(gi));
    end
  endgenerate

  assign w_cur_nib  = w_shadow_dig[r_idx];
  assign w_dp       = |(dp_mask & w_onehot);
  assign w_lz_blank = blank_en && (r_idx == IDX_LAST) && (w_shadow_dig[NUM_DIG-1] == 4'h0);

  seg7_decode u_decode (
    .i_nib (w_cur_nib),
    .o_seg (w_dec)
  );

  always_comb begin
    w_seg_hi = 8'h00;
    w_sel_hi = 6'h00;
    if (w_phase == PH_SHOW) begin
      w_sel_hi = w_onehot;
      w_seg_hi = {w_dp, (w_lz_blank ? 7'h00 : w_dec)};
    end
  end

  always_ff @(posedge clk_sys or negedge nRST) begin
    if (!nRST) begin
      r_pcnt       <= '0;
      r_idx        <= '0;
      r_s1         <= '0;
      r_s2         <= '0;
      r_shadow     <= '0;
      r_seg        <= SEG_OFF;
      r_sel        <= SEL_OFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_pcnt <= w_slot_end ? '0 : r_pcnt + 1'b1;
      if (w_slot_end) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
      end
      r_s1 <= w_din;
      r_s2 <= r_s1;
      // Only take a snapshot that held for two consecutive samples; a torn
      // multi-bit transfer keeps the previous frame's values instead.
      if (w_frame_end && (r_s1 == r_s2)) begin
        r_shadow <= r_s1;
      end
      r_seg        <= seg_drive(w_seg_hi, SEG_ACT_LOW);
      r_sel        <= sel_drive(w_sel_hi, SEL_ACT_LOW);
      r_frame_tick <= w_frame_end;
    end
  end

  assign seg        = r_seg;
  assign sel        = r_sel;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed self-checking bench for seg_scan_driver (SCAN_DIV=8, BLANK_CYC=2, active-low).
module tb_seg_scan_driver;

  logic       clk_sys;
  logic       nRST;
  logic [3:0] disp_dat_0, disp_dat_1, disp_dat_2, disp_dat_3, disp_dat_4, disp_dat_5;
  logic [5:0] dp_mask;
  logic       blank_en;
  logic [7:0] seg;
  logic [5:0] sel;
  logic       frame_tick;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Hand-computed active-low patterns.
  logic [5:0] sel_tab [6] = '{6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F, 6'h1F};
  // Frame 2 digits 0..5 = 9,5,9,5,3,2
  logic [7:0] f2_seg  [6] = '{8'h90, 8'h92, 8'h90, 8'h92, 8'hB0, 8'hA4};
  logic [3:0] hex_in  [6] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
  logic [7:0] hex_seg [6] = '{8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  seg_scan_driver #(
    .SCAN_DIV    (8),
    .BLANK_CYC   (2),
    .SEG_ACT_LOW (1'b1),
    .SEL_ACT_LOW (1'b1)
  ) dut (
    .clk_sys    (clk_sys),
    .nRST       (nRST),
    .disp_dat_0 (disp_dat_0),
    .disp_dat_1 (disp_dat_1),
    .disp_dat_2 (disp_dat_2),
    .disp_dat_3 (disp_dat_3),
    .disp_dat_4 (disp_dat_4),
    .disp_dat_5 (disp_dat_5),
    .dp_mask    (dp_mask),
    .blank_en   (blank_en),
    .seg        (seg),
    .sel        (sel),
    .frame_tick (frame_tick)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end else begin
      $display("ok   %s cyc=%0d val=%0h", tag, cyc, got);
    end
  endtask

  // One rising edge, then settle on the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk_sys);
    cyc++;
    @(negedge clk_sys);
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  initial begin
    int st, pc, ix;
    nRST       = 1'b0;
    disp_dat_0 = 4'd9;
    disp_dat_1 = 4'd5;
    disp_dat_2 = 4'd9;
    disp_dat_3 = 4'd5;
    disp_dat_4 = 4'd3;
    disp_dat_5 = 4'd2;
    dp_mask    = 6'h00;
    blank_en   = 1'b0;

    repeat (3) @(negedge clk_sys);
    check_eq("rst_seg", 32'(seg), 32'h FF);
    check_eq("rst_sel", 32'(sel), 32'h3F);
    check_eq("rst_tick", 32'(frame_tick), 32'h0);

    nRST = 1'b1;
    cyc  = 0;

    // Frames 1 and 2: blanking pattern, one-hot select, frame_tick cadence, digits.
    for (int k = 1; k <= 96; k++) begin
      step();
      st = cyc - 1;
      pc = st % 8;
      ix = (st / 8) % 6;
      if (pc < 2) begin
        check_eq("blank_sel", 32'(sel), 32'h3F);
        check_eq("blank_seg", 32'(seg), 32'hFF);
      end else begin
        check_eq("show_sel", 32'(sel), 32'(sel_tab[ix]));
        check_eq((k <= 48) ? "f1_seg" : "f2_seg", 32'(seg), (k <= 48) ? 32'hC0 : 32'(f2_seg[ix]));
      end
      check_eq("tick", 32'(frame_tick), (st % 48 == 47) ? 32'h1 : 32'h0);
    end

    // Torn capture: digit 0 goes 0 -> 7 so that s1 != s2 at the boundary.
    disp_dat_0 = 4'd0;
    run_to(147);
    check_eq("f3_d0_zero", 32'(seg), 32'hC0);
    run_to(190);
    disp_dat_0 = 4'd7;
    run_to(192);
    check_eq("f3_tick", 32'(frame_tick), 32'h1);
    run_to(195);
    check_eq("torn_hold_seg", 32'(seg), 32'hC0);
    check_eq("torn_hold_sel", 32'(sel), 32'h3E);
    run_to(243);
    check_eq("late7_seg", 32'(seg), 32'hF8);
    check_eq("late7_sel", 32'(sel), 32'h3E);

    // Leading-zero suppression and live decimal points.
    disp_dat_5 = 4'd0;
    blank_en   = 1'b1;
    dp_mask    = 6'b010100;
    run_to(283);
    check_eq("lz_nonzero_seg", 32'(seg), 32'hA4);
    check_eq("lz_nonzero_sel", 32'(sel), 32'h1F);
    run_to(307);
    check_eq("dp2_seg", 32'(seg), 32'h10);
    check_eq("dp2_sel", 32'(sel), 32'h3B);
    run_to(323);
    check_eq("dp4_seg", 32'(seg), 32'h30);
    check_eq("dp4_sel", 32'(sel), 32'h2F);
    run_to(331);
    check_eq("lz_seg", 32'(seg), 32'hFF);
    check_eq("lz_sel", 32'(sel), 32'h1F);

    // Hex digits A..F on digit 3, one per frame.
    for (int j = 0; j < 6; j++) begin
      disp_dat_3 = hex_in[j];
      run_to(48 * (7 + j) + 27);
      check_eq("hex_seg", 32'(seg), 32'(hex_seg[j]));
      check_eq("hex_sel", 32'(sel), 32'h37);
    end

    // Asynchronous reset in the middle of slot 3.
    run_to(653);
    check_eq("pre_rst_sel", 32'(sel), 32'h37);
    nRST = 1'b0;
    #1;
    check_eq("async_rst_seg", 32'(seg), 32'hFF);
    check_eq("async_rst_sel", 32'(sel), 32'h3F);
    @(negedge clk_sys);
    check_eq("held_rst_sel", 32'(sel), 32'h3F);
    nRST = 1'b1;
    cyc  = 0;
    for (int k = 1; k <= 48; k++) begin
      step();
      if (k <= 2) begin
        check_eq("rs_blank_sel", 32'(sel), 32'h3F);
        check_eq("rs_blank_seg", 32'(seg), 32'hFF);
      end else if (k == 3) begin
        check_eq("rs_slot0_sel", 32'(sel), 32'h3E);
        check_eq("rs_slot0_seg", 32'(seg), 32'hC0);
      end
      check_eq("rs_tick", 32'(frame_tick), (k == 48) ? 32'h1 : 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
